// File: rtl/rvvi_packetizer_pkg.sv
// Shared constants, configuration struct and state type for the RVVI frame packetizer.
// The stream word width, header layout and CSR-count location all live here.
package rvvi_packetizer_pkg;

  typedef struct packed {
    int XLEN;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{XLEN: 64};

  localparam int TX_W          = 32;
  localparam int WORD_SHIFT    = $clog2(TX_W);
  localparam int HDR_FIELD_W   = 16;
  localparam int LEN_W         = 16;
  localparam int REQ_BITS      = 64;
  localparam int CSR_COUNT_OFS = 168;
  localparam int CSR_COUNT_W   = 12;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } pkt_state_e;

  // Bits in a compressed frame carrying the given number of CSR records.
  function automatic int frame_bits(input int xlen, input int csrs);
    return REQ_BITS + 4 * xlen + csrs * (xlen + 16);
  endfunction

  function automatic int words_for(input int bits);
    return (bits + TX_W - 1) / TX_W;
  endfunction

endpackage

// File: rtl/rvvi_packetizer_framelen.sv
// Combinational frame-length calculator: CSR record count to payload bits/words.
module rvvi_framelen
  import rvvi_packetizer_pkg::*;
#(
  parameter cvw_t P        = CVW_DEFAULT,
  parameter int   MAX_CSRS = 5
) (
  input  logic [CSR_COUNT_W-1:0] csr_count,
  output logic [LEN_W-1:0]       payload_bits,
  output logic [LEN_W-1:0]       payload_words
);

  logic [CSR_COUNT_W-1:0] csrs;

  // A corrupt or oversized count is clamped so the frame never reads past the input vector.
  always_comb begin
    csrs          = (csr_count > CSR_COUNT_W'(MAX_CSRS)) ? CSR_COUNT_W'(MAX_CSRS) : csr_count;
    payload_bits  = LEN_W'(frame_bits(P.XLEN, int'(csrs)));
    payload_words = LEN_W'(words_for(frame_bits(P.XLEN, int'(csrs))));
  end

endmodule

// File: rtl/rvvi_packetizer.sv
// Serialises one captured RVVI frame into a 32-bit valid/ready stream: a header word
// {PayloadWords, FrameCount} followed by the payload, stalling the core while busy.
module rvvi_packetizer
  import rvvi_packetizer_pkg::*;
#(
  parameter cvw_t P                 = CVW_DEFAULT,
  parameter int   MAX_CSRS          = 5,
  parameter int   RVVI_WIDTH        = frame_bits(P.XLEN, MAX_CSRS),
  parameter int   FRAME_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         DutValid,
  input  logic [RVVI_WIDTH-1:0]        DutRvvi,
  input  logic [FRAME_COUNT_WIDTH-1:0] DutFrameCount,
  output logic                         RvviStall,
  output logic [TX_W-1:0]              TxData,
  output logic                         TxValid,
  input  logic                         TxReady,
  output logic                         TxLast,
  output logic                         Overflow
);

  localparam int MAX_WORDS = words_for(RVVI_WIDTH);
  localparam int IDX_W     = $clog2(MAX_WORDS + 1);
  localparam int PAD_W     = MAX_WORDS * TX_W;

  pkt_state_e             state, state_next;
  logic [IDX_W-1:0]       idx, idx_next, last_idx;
  logic [RVVI_WIDTH-1:0]  held;
  logic [HDR_FIELD_W-1:0] held_count, held_words;
  logic [LEN_W-1:0]       held_bits;
  logic [LEN_W-1:0]       fl_bits, fl_words;
  logic                   capture, beat;

  rvvi_framelen #(
    .P        (P),
    .MAX_CSRS (MAX_CSRS)
  ) u_framelen (
    .csr_count     (DutRvvi[P.XLEN+CSR_COUNT_OFS +: CSR_COUNT_W]),
    .payload_bits  (fl_bits),
    .payload_words (fl_words)
  );

  assign capture   = (state == IDLE) && DutValid;
  assign TxValid   = (state != IDLE);
  assign RvviStall = (state != IDLE);
  assign beat      = TxValid && TxReady;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: if (DutValid) begin
        state_next = HDR;
        idx_next   = '0;
      end
      HDR: if (beat) begin
        state_next = DATA;
        idx_next   = '0;
      end
      DATA: if (beat) begin
        if (idx == last_idx) state_next = IDLE;
        else                 idx_next   = idx + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      Overflow <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (DutValid && (state != IDLE)) Overflow <= 1'b1;
    end
  end

  // NOTE: the holding register is deliberately not reset; after reset the FSM sits in IDLE
  // and nothing reads it until the next capture overwrites every field.
  always_ff @(posedge clk) begin
    if (capture) begin
      held       <= DutRvvi;
      held_count <= HDR_FIELD_W'(DutFrameCount);
      held_words <= fl_words;
      held_bits  <= fl_bits;
      last_idx   <= IDX_W'(fl_words - 1'b1);
    end
  end

  logic [PAD_W-1:0]  padded;
  logic [TX_W-1:0]   words [MAX_WORDS];
  logic [LEN_W-1:0]  word_base, bits_left;
  logic [TX_W-1:0]   tail_mask;

  assign padded = PAD_W'(held);

  always_comb begin
    for (int k = 0; k < MAX_WORDS; k++) words[k] = padded[k*TX_W +: TX_W];
  end

  // Bits of the current word at or above PayloadBits belong to unused CSR slots and read as zero.
  always_comb begin
    word_base = {{(LEN_W-IDX_W-WORD_SHIFT){1'b0}}, idx, {WORD_SHIFT{1'b0}}};
    bits_left = held_bits - word_base;
    tail_mask = (bits_left < LEN_W'(TX_W)) ? ~({TX_W{1'b1}} << bits_left[WORD_SHIFT-1:0])
                                           : {TX_W{1'b1}};
  end

  always_comb begin
    TxData = '0;
    TxLast = 1'b0;
    case (state)
      HDR:  TxData = {held_words, held_count};
      DATA: begin
        TxData = words[idx] & tail_mask;
        TxLast = (idx == last_idx);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rvvi_packetizer.sv
// Directed self-checking bench for rvvi_packetizer at XLEN=64, MAX_CSRS=5 (720-bit frames).
module tb_rvvi_packetizer;

  localparam int W = 720;

  logic          clk = 1'b0;
  logic          reset;
  logic          DutValid;
  logic [W-1:0]  DutRvvi;
  logic [15:0]   DutFrameCount;
  logic          RvviStall;
  logic [31:0]   TxData;
  logic          TxValid;
  logic          TxReady;
  logic          TxLast;
  logic          Overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rvvi_packetizer dut (
    .clk           (clk),
    .reset         (reset),
    .DutValid      (DutValid),
    .DutRvvi       (DutRvvi),
    .DutFrameCount (DutFrameCount),
    .RvviStall     (RvviStall),
    .TxData        (TxData),
    .TxValid       (TxValid),
    .TxReady       (TxReady),
    .TxLast        (TxLast),
    .Overflow      (Overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every 32-bit slot is non-zero so zeroing of bits above PayloadBits is observable.
  function automatic logic [W-1:0] make_frame(input logic [7:0] seed, input logic [11:0] csrs);
    logic [W-1:0] f;
    f = '0;
    for (int k = 0; k < 22; k++)
      f[32*k +: 32] = {seed, 8'(k), 8'h5A ^ 8'(k), ~seed};
    f[719:704] = {seed, 8'hC3};
    f[243:232] = csrs;
    return f;
  endfunction

  function automatic logic [31:0] exp_word(input logic [W-1:0] f, input int k, input int pb);
    logic [W+31:0] ext;
    logic [31:0]   w;
    ext = {32'b0, f};
    w   = ext[32*k +: 32];
    for (int b = 0; b < 32; b++)
      if (32*k + b >= pb) w[b] = 1'b0;
    return w;
  endfunction

  // Called #1 after a posedge; presents a frame for one cycle while the DUT is idle.
  task automatic start(input logic [W-1:0] f, input logic [15:0] fc);
    DutValid      = 1'b1;
    DutRvvi       = f;
    DutFrameCount = fc;
    @(negedge clk);
    check("idle_valid", 32'(TxValid), 32'd0);
    check("idle_stall", 32'(RvviStall), 32'd0);
    @(posedge clk);
    #1 DutValid = 1'b0;
  endtask

  // Follows one frame from its header to the accepted last word; returns #1 after that edge.
  task automatic run_frame(input logic [W-1:0] f, input logic [15:0] fc, input int csrs_eff,
                           input bit toggle, input int pulse);
    int          pb, words, beats, cyc, stall_cnt;
    bit          done, prev_hold;
    logic [31:0] prev_data, expd;
    logic        prev_last;
    pb        = 320 + 80 * csrs_eff;
    words     = (pb + 31) / 32;
    beats     = 0;
    cyc       = 0;
    stall_cnt = 0;
    done      = 1'b0;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    TxReady   = !toggle;
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (RvviStall) stall_cnt++;
      check("tx_valid", 32'(TxValid), 32'd1);
      if (prev_hold) begin
        check("hold_data", TxData, prev_data);
        check("hold_last", 32'(TxLast), 32'(prev_last));
      end
      expd = (beats == 0) ? {16'(words), fc} : exp_word(f, beats - 1, pb);
      check($sformatf("tx_data[%0d]", beats), TxData, expd);
      check($sformatf("tx_last[%0d]", beats), 32'(TxLast), 32'(beats == words));
      prev_hold = !TxReady;
      prev_data = TxData;
      prev_last = TxLast;
      if (TxReady) begin
        if (beats == words) done = 1'b1;
        beats++;
      end
      cyc++;
      @(posedge clk);
      #1;
      if (toggle) TxReady = ~TxReady;
      if (pulse >= 0) begin
        DutValid = (cyc == pulse);
        DutRvvi  = ~f;
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    check("beats", 32'(beats), 32'(words + 1));
    check("stall_cycles", 32'(stall_cnt), toggle ? 32'(2 * (words + 1)) : 32'(words + 1));
    DutValid = 1'b0;
    TxReady  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] f;
    logic [W-1:0] g;
    reset         = 1'b1;
    DutValid      = 1'b0;
    DutRvvi       = '0;
    DutFrameCount = '0;
    TxReady       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(TxValid), 32'd0);
    check("rst_data", TxData, 32'd0);
    check("rst_last", 32'(TxLast), 32'd0);
    check("rst_stall", 32'(RvviStall), 32'd0);
    check("rst_ovf", 32'(Overflow), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // No CSRs: 10 payload words, header 0x000A_0001.
    f = make_frame(8'h11, 12'd0);
    start(f, 16'h0001);
    run_frame(f, 16'h0001, 0, 1'b0, -1);

    // Full frame: 23 words, upper half of the final word zeroed.
    f = make_frame(8'h22, 12'd5);
    start(f, 16'h0002);
    run_frame(f, 16'h0002, 5, 1'b0, -1);

    // Two CSRs with the sink toggling ready every cycle.
    f = make_frame(8'h33, 12'd2);
    start(f, 16'hBEEF);
    run_frame(f, 16'hBEEF, 2, 1'b1, -1);

    // Out-of-range CSR count clamps to five.
    f = make_frame(8'h44, 12'hFFF);
    start(f, 16'h1234);
    run_frame(f, 16'h1234, 5, 1'b0, -1);

    // A frame offered in the third cycle of a busy frame is dropped and flagged.
    @(negedge clk);
    check("ovf_before", 32'(Overflow), 32'd0);
    @(posedge clk);
    #1;
    f = make_frame(8'h55, 12'd1);
    start(f, 16'h0055);
    run_frame(f, 16'h0055, 1, 1'b0, 2);
    @(negedge clk);
    check("ovf_set", 32'(Overflow), 32'd1);
    check("ovf_no_extra", 32'(TxValid), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back: next capture in the cycle right after the last handshake.
    f = make_frame(8'h66, 12'd1);
    g = make_frame(8'h77, 12'd3);
    start(f, 16'h0066);
    run_frame(f, 16'h0066, 1, 1'b0, -1);
    start(g, 16'h0077);
    run_frame(g, 16'h0077, 3, 1'b0, -1);
    @(negedge clk);
    check("ovf_sticky", 32'(Overflow), 32'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of the payload.
    f = make_frame(8'h88, 12'd4);
    start(f, 16'h0088);
    TxReady = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", 32'(TxValid), 32'd0);
    check("mid_rst_stall", 32'(RvviStall), 32'd0);
    check("mid_rst_data", TxData, 32'd0);
    check("mid_rst_last", 32'(TxLast), 32'd0);
    check("mid_rst_ovf", 32'(Overflow), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(TxValid), 32'd0);
    end
    @(posedge clk);
    #1;
    f = make_frame(8'h99, 12'd0);
    start(f, 16'h0099);
    run_frame(f, 16'h0099, 0, 1'b0, -1);

    @(negedge clk);
    check("end_idle", 32'(TxValid), 32'd0);
    check("end_stall", 32'(RvviStall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
